load_store_unit: RTL and testbench

Load/store unit between the core's execute stage and the data TCM. Accepts one byte/halfword/word load or store per request and converts it into word-aligned TCM accesses with byte enables. An access that crosses a word boundary is split into two TCM accesses. Load data is reassembled, shifted and sign- or zero-extended before it is returned to the core.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle between the core, the load/store unit and the data TCM.
// The slave modport is the load/store unit itself. The master modport is its
// environment: the core request side plus the TCM read-data return.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_data_i;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_addr_o, mem_data_o, mem_we_o, mem_be_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_addr_o, mem_data_o, mem_we_o, mem_be_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request into one or two
// word-aligned TCM accesses and returns extended load data.
//
//   state | meaning
//   IDLE  | ready for a new request
//   ACC0  | TCM access to the word holding the first byte
//   ACC1  | TCM access to the following word (misaligned spill-over)
//   RESP  | one-cycle response pulse to the core
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           lo_buf, hi_buf;

  logic                  accept;
  logic [1:0]            off;
  logic [3:0]            base_mask;
  logic [7:0]            mask;
  logic [63:0]           lane;
  logic [63:0]           raw;
  logic                  split;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           load_data;

  assign accept = bus.req_valid_i && bus.req_ready_o;

  // Byte mask, lane-shifted store data and reassembled load data for the held request.
  always_comb begin
    off = addr_q[1:0];
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask      = {4'b0000, base_mask} << off;
    lane      = {32'h0, wdata_q} << {off, 3'b000};
    split     = |mask[7:4];
    word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    // Truncation to the access size keeps stale buffer bytes out of the result.
    raw       = {hi_buf, lo_buf} >> {off, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & raw[7]}}, raw[7:0]};
      2'b01:   load_data = {{16{~uns_q & raw[15]}}, raw[15:0]};
      default: load_data = raw[31:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an illegal size skips the TCM entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (bus.req_size_i == 2'b11) ? RESP : ACC0;
      ACC0: state_d = split ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load-data buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lo_buf  <= 32'h0;
      hi_buf  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we_i;
        uns_q   <= bus.req_unsigned_i;
        size_q  <= bus.req_size_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        err_q   <= (bus.req_size_i == 2'b11);
      end
      if (state_q == ACC0 && !we_q) lo_buf <= bus.mem_data_i;
      if (state_q == ACC1 && !we_q) hi_buf <= bus.mem_data_i;
    end
  end

  // Outputs decoded from state; everything idles at zero outside the access states.
  always_comb begin
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_rdata_o = 32'h0;
    bus.rsp_err_o   = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = 32'h0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0000;
    case (state_q)
      IDLE: bus.req_ready_o = 1'b1;
      ACC0: begin
        bus.mem_addr_o = word_addr;
        bus.mem_be_o   = mask[3:0];
        bus.mem_data_o = lane[31:0];
        bus.mem_we_o   = we_q;
      end
      ACC1: begin
        bus.mem_addr_o = word_addr + ADDR_WIDTH'(4);
        bus.mem_be_o   = mask[7:4];
        bus.mem_data_o = lane[63:32];
        bus.mem_we_o   = we_q;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = err_q;
        bus.rsp_rdata_o = (we_q || err_q) ? 32'h0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests with hand-derived load results,
// a byte-wise model of the expected TCM accesses, and a scoreboard that matches
// accesses and responses against the cycle they must appear in.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] tcm [0:255];
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  vec_t vecs[$];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected accesses and responses.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Small TCM: 256 words, combinational read, byte-enabled write on the edge.
  assign bus.mem_data_i = tcm[bus.mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tcm[i] <= 32'h0;
      tcm[255] <= 32'h3400_0000;
      tcm[0]   <= 32'h0000_0092;
    end else if (bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be_o[b]) tcm[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares bus activity against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(bus.req_ready_o), 32'(rsp_q.size() == 0));
      if (bus.mem_we_o || bus.mem_be_o != 4'b0000) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 32'(bus.mem_be_o), 32'h0);
        end else begin
          acc_t a;
          logic [31:0] m;
          a = acc_q.pop_front();
          m = {{8{a.be[3]}}, {8{a.be[2]}}, {8{a.be[1]}}, {8{a.be[0]}}};
          chk("mem_addr", bus.mem_addr_o, a.addr);
          chk("mem_be", 32'(bus.mem_be_o), 32'(a.be));
          chk("mem_we", 32'(bus.mem_we_o), 32'(a.we));
          chk("acc_cycle", edge_cnt, a.cyc);
          if (a.we) chk("mem_data", bus.mem_data_o & m, a.data & m);
        end
      end
      if (bus.rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid_o), 32'h0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata_o, r.rdata);
          chk("rsp_err", 32'(bus.rsp_err_o), 32'(r.err));
          chk("rsp_cycle", edge_cnt, r.cyc);
        end
      end
    end
  end

  // Expected accesses built byte by byte: each byte lands in whichever word holds it.
  task automatic push_exp(input vec_t v, input int k);
    acc_t a0, a1;
    logic have1;
    logic [31:0] ad;
    int n;
    if (v.size == 2'b11) begin
      rsp_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: k});
      return;
    end
    n = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    a0 = '{addr: {v.addr[31:2], 2'b00}, be: 4'b0000, data: 32'h0, we: v.we, cyc: k};
    a1 = '{addr: 32'h0, be: 4'b0000, data: 32'h0, we: v.we, cyc: k + 1};
    have1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      ad = v.addr + 32'(i);
      if ({ad[31:2], 2'b00} == a0.addr) begin
        a0.be[ad[1:0]] = 1'b1;
        a0.data[8*ad[1:0] +: 8] = v.wdata[8*i +: 8];
      end else begin
        have1 = 1'b1;
        a1.addr = {ad[31:2], 2'b00};
        a1.be[ad[1:0]] = 1'b1;
        a1.data[8*ad[1:0] +: 8] = v.wdata[8*i +: 8];
      end
    end
    acc_q.push_back(a0);
    if (have1) acc_q.push_back(a1);
    rsp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, cyc: have1 ? k + 2 : k + 1});
  endtask

  // Drive one request as soon as the unit is ready; returns 1 ns after the accept edge.
  task automatic send(input vec_t v);
    int w = 0;
    while (!bus.req_ready_o && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      chk("ready_timeout", 32'(bus.req_ready_o), 32'h1);
      return;
    end
    bus.req_we_i       = v.we;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_addr_i     = v.addr;
    bus.req_wdata_i    = v.wdata;
    bus.req_valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    push_exp(v, edge_cnt);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata,
          exp_rdata: exp_rdata, exp_err: exp_err};
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_wdata_i    = 32'h0;

    //                  we    size   uns   addr          wdata         rdata         err
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         32'h0000_0080, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1122_3344, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h1122_3344, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_9234, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_0104, 32'h5555_AAAA, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_44BE, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         32'hFFFF_FFBE, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0,         32'h0000_2233, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0105, 32'hFFFF_CAFE, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         32'h00CA_FE22, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0105, 32'h0,         32'hFFFF_CAFE, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0105, 32'h0,         32'h0000_CAFE, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0107, 32'h1234_5677, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         32'h77CA_FE22, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0107, 32'hBEEF_8001, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0107, 32'h0,         32'hFFFF_8001, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0108, 32'h0,         32'h0000_0080, 1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0092_3400, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_data", bus.mem_data_o, 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_mem_be", 32'(bus.mem_be_o), 32'h0);
    rst = 1'b0;
    init_mem = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i]);

    // Reset during ACC1 of a split store: low half stays written, no response.
    send(mk(1'b1, 2'b10, 1'b0, 32'h0000_0206, 32'hAABB_CCDD, 32'h0, 1'b0));
    @(posedge clk); #1;
    chk("abort_in_acc1_be", 32'(bus.mem_be_o), 32'h3);
    rst = 1'b1;
    acc_q.delete();
    rsp_q.delete();
    #1;
    chk("abort_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("abort_mem_be", 32'(bus.mem_be_o), 32'h0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("abort_ready", 32'(bus.req_ready_o), 32'h1);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(bus.rsp_valid_o), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    send(mk(1'b0, 2'b10, 1'b0, 32'h0000_0206, 32'h0, 32'h0000_CCDD, 1'b0));

    for (int w = 0; w < 10 && (rsp_q.size() != 0 || acc_q.size() != 0); w++) @(posedge clk);
    #1;
    chk("drain_rsp", 32'(rsp_q.size()), 32'h0);
    chk("drain_acc", 32'(acc_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
